// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register indices and address width for the GPIO block
package gpio_pkg;

    localparam int GPIO_ADDR_W = 5;

    localparam logic [2:0] GPIO_DIR  = 3'd0;
    localparam logic [2:0] GPIO_OUT  = 3'd1;
    localparam logic [2:0] GPIO_IN   = 3'd2;
    localparam logic [2:0] GPIO_SET  = 3'd3;
    localparam logic [2:0] GPIO_CLR  = 3'd4;
    localparam logic [2:0] GPIO_TGL  = 3'd5;
    localparam logic [2:0] GPIO_IE   = 3'd6;
    localparam logic [2:0] GPIO_PEND = 3'd7;

endpackage

// File: rtl/module_gpio_sync.sv
// rtl/module_gpio_sync.sv - WIDTH x SYNC_STAGES input synchronizer chain
module module_gpio_sync #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/module_gpio.sv
// rtl/module_gpio.sv - memory-mapped GPIO with tristate pads and rising-edge interrupts
module module_gpio
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sel,
    input  logic [GPIO_ADDR_W-1:0] addr,
    input  logic                   we,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   irq,
    inout  wire  [WIDTH-1:0]       gpio_ports
);

    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] ie_q;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] pend_next;
    logic [WIDTH-1:0] out_next;
    logic [2:0]       idx;
    logic             wr;
    logic             unused_bits;

    assign idx         = addr[4:2];
    assign wr          = sel && we;
    assign wd          = wdata[WIDTH-1:0];
    assign unused_bits = ^{wdata, addr[1:0]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign gpio_ports[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    module_gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gpio_ports),
        .q     (sync_q)
    );

    // A new edge beats a simultaneous write-one-to-clear on the same bit
    assign rise      = sync_q & ~prev_q;
    assign w1c       = (wr && idx == GPIO_PEND) ? wd : '0;
    assign pend_next = (pend_q & ~w1c) | rise;

    always_comb begin
        out_next = out_q;
        if (wr) begin
            case (idx)
                GPIO_OUT: out_next = wd;
                GPIO_SET: out_next = out_q | wd;
                GPIO_CLR: out_next = out_q & ~wd;
                GPIO_TGL: out_next = out_q ^ wd;
                default:  out_next = out_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q  <= '0;
            out_q  <= '0;
            ie_q   <= '0;
            pend_q <= '0;
            prev_q <= '0;
            irq    <= 1'b0;
        end else begin
            out_q  <= out_next;
            pend_q <= pend_next;
            prev_q <= sync_q;
            irq    <= |(pend_next & ie_q);
            if (wr && idx == GPIO_DIR) begin
                dir_q <= wd;
            end
            if (wr && idx == GPIO_IE) begin
                ie_q <= wd;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (idx)
                GPIO_DIR:  rdata[WIDTH-1:0] = dir_q;
                GPIO_OUT:  rdata[WIDTH-1:0] = out_q;
                GPIO_IN:   rdata[WIDTH-1:0] = sync_q;
                GPIO_IE:   rdata[WIDTH-1:0] = ie_q;
                GPIO_PEND: rdata[WIDTH-1:0] = pend_q;
                default:   rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_module_gpio.sv
// tb/tb_module_gpio.sv - scoreboard bench for module_gpio with a pin-history reference model
module tb_module_gpio;
    import gpio_pkg::*;

    localparam int W = 16;
    localparam int S = 2;

    typedef struct {
        logic [31:0]  rdata;
        logic         irq;
        logic [W-1:0] pads;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         sel;
    logic [4:0]   addr;
    logic         we;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         irq;
    wire  [W-1:0] pads;

    logic [W-1:0] tb_en  = '0;
    logic [W-1:0] tb_val = '0;

    int checks   = 0;
    int failures = 0;

    exp_t         sb[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] m_dir, m_out, m_ie, m_pend;
    logic         m_irq;

    always #5 clk = ~clk;

    for (genvar i = 0; i < W; i++) begin : g_pins
        assign pads[i] = tb_en[i] ? tb_val[i] : 1'bz;
        pulldown (pads[i]);
    end

    module_gpio #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .addr       (addr),
        .we         (we),
        .wdata      (wdata),
        .rdata      (rdata),
        .irq        (irq),
        .gpio_ports (pads)
    );

    // Pin value sampled k edges ago (0 = most recent); nothing before reset
    function automatic logic [W-1:0] hist_at(input int k);
        return (k < hist.size()) ? hist[k] : '0;
    endfunction

    function automatic logic [W-1:0] model_pads();
        logic [W-1:0] p;
        for (int i = 0; i < W; i++) begin
            p[i] = m_dir[i] ? m_out[i] : (tb_en[i] ? tb_val[i] : 1'b0);
        end
        return p;
    endfunction

    function automatic logic [31:0] model_read(input logic s, input logic [4:0] a);
        logic [31:0] r;
        r = '0;
        if (s) begin
            case (a[4:2])
                GPIO_DIR:  r[W-1:0] = m_dir;
                GPIO_OUT:  r[W-1:0] = m_out;
                GPIO_IN:   r[W-1:0] = hist_at(S-1);
                GPIO_IE:   r[W-1:0] = m_ie;
                GPIO_PEND: r[W-1:0] = m_pend;
                default:   r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        m_dir = '0; m_out = '0; m_ie = '0; m_pend = '0; m_irq = 1'b0;
        hist.delete();
    endtask

    task automatic model_edge(input logic r, input logic s, input logic w,
                              input logic [4:0] a, input logic [31:0] d);
        logic [W-1:0] rise, clr, pend_n, pad_now, v;
        if (r) begin
            model_reset();
            return;
        end
        v       = d[W-1:0];
        rise    = hist_at(S-1) & ~hist_at(S);
        clr     = (s && w && a[4:2] == GPIO_PEND) ? v : '0;
        pend_n  = (m_pend & ~clr) | rise;
        m_irq   = |(pend_n & m_ie);
        pad_now = model_pads();
        if (s && w) begin
            case (a[4:2])
                GPIO_DIR: m_dir = v;
                GPIO_OUT: m_out = v;
                GPIO_SET: m_out = m_out | v;
                GPIO_CLR: m_out = m_out & ~v;
                GPIO_TGL: m_out = m_out ^ v;
                GPIO_IE:  m_ie  = v;
                default: ;
            endcase
        end
        m_pend = pend_n;
        hist.push_front(pad_now);
        if (hist.size() > S + 1) void'(hist.pop_back());
    endtask

    task automatic cyc(input logic r, input logic s, input logic w,
                       input logic [2:0] reg_idx, input logic [31:0] d);
        exp_t e;
        reset = r; sel = s; we = w; addr = {reg_idx, 2'($urandom_range(0, 3))}; wdata = d;
        e.rdata = model_read(s, addr);
        e.irq   = m_irq;
        e.pads  = model_pads();
        sb.push_back(e);
        @(posedge clk);
        model_edge(r, s, w, addr, d);
        #1;
    endtask

    task automatic rd(input logic [2:0] reg_idx);
        cyc(1'b0, 1'b1, 1'b0, reg_idx, $urandom);
    endtask

    task automatic wr(input logic [2:0] reg_idx, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b1, reg_idx, d);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rdata", rdata, e.rdata);
            chk("irq", {31'b0, irq}, {31'b0, e.irq});
            chk("pads", {{(32-W){1'b0}}, pads}, {{(32-W){1'b0}}, e.pads});
        end
    end

    initial begin
        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        rd(GPIO_DIR); rd(GPIO_OUT); rd(GPIO_IE); rd(GPIO_PEND); rd(GPIO_IN);

        // Direction and output, IN readback through the synchronizer
        wr(GPIO_DIR, 32'h0000_00FF);
        wr(GPIO_OUT, 32'hFFFF_A5A5);
        repeat (3) rd(GPIO_IN);
        rd(GPIO_DIR);

        // Set / clear / toggle
        wr(GPIO_OUT, 32'h0F0F); rd(GPIO_OUT);
        wr(GPIO_SET, 32'h00F0); rd(GPIO_OUT);
        wr(GPIO_CLR, 32'h0F00); rd(GPIO_OUT);
        wr(GPIO_TGL, 32'hFFFF); rd(GPIO_OUT);
        rd(GPIO_SET); rd(GPIO_CLR); rd(GPIO_TGL);

        // Interrupt on pin15, then W1C, then a pin without IE
        wr(GPIO_IE, 32'h8000);
        wr(GPIO_DIR, 32'h0);
        repeat (4) rd(GPIO_PEND);
        wr(GPIO_PEND, 32'hFFFF_FFFF);
        rd(GPIO_PEND);
        tb_en[15] = 1'b1; tb_val[15] = 1'b1;
        repeat (5) rd(GPIO_PEND);
        wr(GPIO_PEND, 32'h8000);
        repeat (2) rd(GPIO_PEND);
        tb_en[3] = 1'b1; tb_val[3] = 1'b1;
        repeat (5) rd(GPIO_PEND);

        // W1C of bit 4 coinciding with a fresh rise on pin4
        tb_en[4] = 1'b1; tb_val[4] = 1'b1;
        repeat (4) rd(GPIO_PEND);
        tb_val[4] = 1'b0;
        wr(GPIO_PEND, 32'h0010);
        repeat (4) rd(GPIO_PEND);
        tb_val[4] = 1'b1;
        repeat (S) rd(GPIO_IN);
        wr(GPIO_PEND, 32'h0010);
        repeat (2) rd(GPIO_PEND);

        // Deselected accesses
        cyc(1'b0, 1'b0, 1'b0, GPIO_PEND, '0);
        cyc(1'b0, 1'b0, 1'b1, GPIO_OUT, 32'hFFFF);
        cyc(1'b0, 1'b0, 1'b1, GPIO_DIR, 32'hFFFF);
        rd(GPIO_OUT); rd(GPIO_DIR);

        // Reset with pin3 held high: one rise after release
        cyc(1'b1, 1'b1, 1'b0, GPIO_PEND, '0);
        cyc(1'b1, 1'b1, 1'b0, GPIO_PEND, '0);
        repeat (6) rd(GPIO_PEND);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [2:0] ri;
            if ($urandom_range(0, 3) == 0) begin
                tb_val = W'($urandom);
                tb_en  = W'($urandom) & ~m_dir;
            end else begin
                tb_en  = tb_en & ~m_dir;
            end
            ri = 3'($urandom_range(0, 7));
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 2) == 0, ri, $urandom);
        end

        sel = 1'b0; we = 1'b0; reset = 1'b0;
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d entries left expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
